// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants used by fetch and the control
// decoder, the bubble instruction, fetch FSM encoding and the byte-swap helper.
package rv_pkg;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] SAVE   = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] JTYPE  = 7'b1101111;
  localparam logic [6:0] JRTYPE = 7'b1100111;

  // addi x0,x0,0
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

  // The I-cache returns words in little-endian byte order; the pipeline
  // wants the instruction with byte 0 in the top lane reversed back.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache read port between the fetch stage and the I-cache.
interface fetch_stage_if;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;

  modport master (
    output ICACHE_ren,
    output ICACHE_addr,
    input  ICACHE_rdata,
    input  ICACHE_stall
  );

  modport slave (
    input  ICACHE_ren,
    input  ICACHE_addr,
    output ICACHE_rdata,
    output ICACHE_stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to the I-cache and
// fills the IF/ID register. Handles ID redirects, ID hazard stalls and
// I-cache miss stalls.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | single cycle after reset, no cache request
// S_FETCH | requesting pc[31:2] every cycle
// S_DROP  | redirect seen during a miss; wait out the stale access, discard it
module fetch_stage
  import rv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        icache,
  input  logic                 stall_id,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 ifid_valid,
  output logic [31:0]          ifid_pc,
  output logic [31:0]          ifid_pc4,
  output logic [31:0]          ifid_inst,
  output logic [6:0]           ifid_opcode
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  ifid_pc_q, ifid_pc_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;
  logic [31:0]  ifid_inst_q, ifid_inst_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_tgt;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Cache request is a pure function of state and pc; pc never moves while
  // the cache stalls, so the address stays stable across a miss.
  always_comb begin
    icache.ICACHE_ren  = (state_q != S_IDLE);
    icache.ICACHE_addr = pc_q[31:2];
  end

  // Next-state, PC and IF/ID update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_inst_d  = ifid_inst_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect_valid) begin
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP;
          if (icache.ICACHE_stall) begin
            // Access still outstanding: remember the target, keep the
            // address stable until the cache finishes.
            pend_pc_d = redirect_tgt;
            state_d   = S_DROP;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (stall_id) begin
          // Hold everything; this cycle's word is simply re-read later.
        end else if (icache.ICACHE_stall) begin
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP;
        end else begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_inst_d  = bswap32(icache.ICACHE_rdata);
          pc_d         = pc_plus4;
        end
      end

      S_DROP: begin
        if (icache.ICACHE_stall) begin
          if (redirect_valid) begin
            pend_pc_d = redirect_tgt;
          end
        end else begin
          // Stale word is discarded. A redirect arriving in this same cycle
          // is newer than the pending one, so it takes precedence.
          pc_d    = redirect_valid ? redirect_tgt : pend_pc_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_inst_q  <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
    end
  end

  // IF/ID outputs; the opcode field feeds the decoder directly.
  always_comb begin
    ifid_valid  = ifid_valid_q;
    ifid_pc     = ifid_pc_q;
    ifid_pc4    = ifid_pc4_q;
    ifid_inst   = ifid_inst_q;
    ifid_opcode = ifid_inst_q[6:0];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The I-cache model returns, for word
// address a, the little-endian image of instruction exp_inst(a).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic [6:0]  ifid_opcode;

  int total = 0;
  int bad   = 0;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .icache         (bus.master),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc4       (ifid_pc4),
    .ifid_inst      (ifid_inst),
    .ifid_opcode    (ifid_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_inst(input logic [29:0] a);
    if (a == 30'd0) return 32'h0000_0013;
    if (a == 30'd1) return 32'h0000_0093;
    return {a[24:0], 7'h33};
  endfunction

  always_comb begin
    logic [31:0] w;
    w = exp_inst(bus.ICACHE_addr);
    bus.ICACHE_rdata = {w[7:0], w[15:8], w[23:16], w[31:24]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string name, input logic v, input logic [31:0] pc,
                        input logic [29:0] addr);
    total++;
    if (ifid_valid !== v || (v && ifid_pc !== pc) || bus.ICACHE_addr !== addr ||
        bus.ICACHE_ren !== 1'b1) begin
      bad++;
      $display("FAIL %s: got valid=%0b pc=%h addr=%h ren=%0b want valid=%0b pc=%h addr=%h ren=1",
               name, ifid_valid, ifid_pc, bus.ICACHE_addr, bus.ICACHE_ren, v, pc, addr);
    end
    total++;
    if (v && (ifid_inst !== exp_inst(pc[31:2]) || ifid_pc4 !== pc + 32'd4)) begin
      bad++;
      $display("FAIL %s_data: got inst=%h pc4=%h want inst=%h pc4=%h",
               name, ifid_inst, ifid_pc4, exp_inst(pc[31:2]), pc + 32'd4);
    end else if (!v && ifid_inst !== 32'h0000_0013) begin
      bad++;
      $display("FAIL %s_bubble: got inst=%h want 00000013", name, ifid_inst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    bus.ICACHE_stall = 1'b0;
    step(); step();
    total++;
    if ({bus.ICACHE_ren, bus.ICACHE_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_inst, ifid_opcode}
        !== {1'b0, 30'd0, 1'b0, 32'd0, 32'd0, 32'h13, 7'h13}) begin
      bad++;
      $display("FAIL reset: got ren=%0b addr=%h v=%0b pc=%h pc4=%h inst=%h op=%h want all reset",
               bus.ICACHE_ren, bus.ICACHE_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_inst, ifid_opcode);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.ICACHE_ren !== 1'b1 || ifid_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req: got ren=%0b valid=%0b want ren=1 valid=0", bus.ICACHE_ren, ifid_valid);
    end
  endtask

  task automatic test_hits();
    step();
    chk_if("hit0", 1'b1, 32'h0, 30'h1);
    step();
    chk_if("hit4", 1'b1, 32'h4, 30'h2);
    total++;
    if (ifid_inst !== 32'h0000_0093 || ifid_opcode !== 7'h13) begin
      bad++;
      $display("FAIL hit4_op: got inst=%h op=%h want 00000093 13", ifid_inst, ifid_opcode);
    end
  endtask

  task automatic test_miss();
    bus.ICACHE_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("miss_hold", 1'b0, 32'h0, 30'h2);
    end
    bus.ICACHE_stall = 1'b0;
    step();
    chk_if("miss_done", 1'b1, 32'h8, 30'h3);
    step();
    chk_if("after_miss", 1'b1, 32'hC, 30'h4);
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    chk_if("redir_bubble", 1'b0, 32'h0, 30'h40);
    redirect_valid = 1'b0;
    step();
    chk_if("redir_target", 1'b1, 32'h100, 30'h41);
  endtask

  task automatic test_drop_miss();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    bus.ICACHE_stall = 1'b1;
    step();
    chk_if("drop_miss1", 1'b0, 32'h0, 30'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk_if("drop_redir", 1'b0, 32'h0, 30'h8);
    redirect_valid = 1'b0;
    step();
    chk_if("drop_wait1", 1'b0, 32'h0, 30'h8);
    step();
    chk_if("drop_wait2", 1'b0, 32'h0, 30'h8);
    bus.ICACHE_stall = 1'b0;
    step();
    chk_if("drop_discard", 1'b0, 32'h0, 30'h10);
    step();
    chk_if("drop_target", 1'b1, 32'h40, 30'h11);
  endtask

  task automatic test_stall_id();
    stall_id = 1'b1;
    step();
    chk_if("sid_freeze", 1'b1, 32'h40, 30'h11);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    chk_if("sid_redir", 1'b0, 32'h0, 30'h20);
    stall_id = 1'b0; redirect_valid = 1'b0;
    step();
    chk_if("sid_target", 1'b1, 32'h80, 30'h21);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk_if("wrap", 1'b1, 32'hFFFF_FFFC, 30'h0);
    total++;
    if (ifid_pc4 !== 32'h0 || ifid_inst !== 32'hFFFF_FFB3) begin
      bad++;
      $display("FAIL wrap_pc4: got pc4=%h inst=%h want 00000000 ffffffb3", ifid_pc4, ifid_inst);
    end
  endtask

  task automatic test_rst_mid_miss();
    bus.ICACHE_stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    total++;
    if ({bus.ICACHE_ren, bus.ICACHE_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_inst, ifid_opcode}
        !== {1'b0, 30'd0, 1'b0, 32'd0, 32'd0, 32'h13, 7'h13}) begin
      bad++;
      $display("FAIL rst_mid_miss: got ren=%0b addr=%h v=%0b pc=%h pc4=%h inst=%h op=%h want all reset",
               bus.ICACHE_ren, bus.ICACHE_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_inst, ifid_opcode);
    end
    rst = 1'b0; bus.ICACHE_stall = 1'b0;
    step();
    total++;
    if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h0) begin
      bad++;
      $display("FAIL restart_req: got ren=%0b addr=%h want 1 0", bus.ICACHE_ren, bus.ICACHE_addr);
    end
    step();
    chk_if("restart_hit", 1'b1, 32'h0, 30'h1);
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_redirect();
    test_drop_miss();
    test_stall_id();
    test_wrap();
    test_rst_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core: owns the PC, issues word reads to the instruction cache, and fills the IF/ID pipeline register whose opcode field drives the control decoder directly downstream. It accepts PC redirects (taken branch, JAL, JALR) resolved in ID and inserts bubbles on them. It also honours the ID-stage hazard stall and I-cache miss stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP, 32'h0000_0013, instruction word placed in IF/ID on bubbles (addi x0,x0,0).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; **one clock, synchronous, active-high reset**.
- ICACHE_ren  out  1  read request to the I-cache.
- ICACHE_addr  out  30  word address, equal to pc[31:2].
- ICACHE_rdata  in  32  fetched word, little-endian byte order; valid when ren=1 and ICACHE_stall=0.
- ICACHE_stall  in  1  cache busy; the address must be held stable while it is high.
- stall_id  in  1  load-use or other downstream hazard; freezes the PC and IF/ID.
- redirect_valid  in  1  taken branch, JAL, or JALR; ID asserts this when the decoder raises flush or branch resolves taken.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_pc4  out  32  ifid_pc+4, used as the JAL/JALR link value.
- ifid_inst  out  32  instruction word after byte swap.
- ifid_opcode  out  7  ifid_inst[6:0]; feeds the decoder.

## Operation
- Byte swap: ifid_inst = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}.
- The FSM has three states:
  - S_IDLE: the single cycle after reset. ren=0. Next state is S_FETCH.
  - S_FETCH: ren=1, addr=pc[31:2].
  - S_DROP: ren=1, addr held at the stale pc. A redirect arrived while a cache access was outstanding, and the response must be consumed and discarded.
- Priority in S_FETCH each cycle: rst > redirect_valid > stall_id > ICACHE_stall > normal fetch.
  - redirect_valid and ICACHE_stall=0: pc<=redirect_pc; ifid_valid<=0; ifid_inst<=NOP.
  - redirect_valid and ICACHE_stall=1: pend_pc<=redirect_pc; state<=S_DROP; ifid_valid<=0; ifid_inst<=NOP; pc held.
  - stall_id (no redirect): pc and all ifid_* held; the cache word is discarded and re-read later.
  - ICACHE_stall only: pc held; ifid_valid<=0; ifid_inst<=NOP. This is a bubble, since ID proceeds.
  - Otherwise: IF/ID <= {1, pc, pc+4, swapped rdata}; pc<=pc+4.
- S_DROP:
  - While ICACHE_stall=1, stay. A further redirect overwrites pend_pc.
  - When ICACHE_stall=0, discard rdata, set pc<=pend_pc, return to S_FETCH. IF/ID keeps its bubble.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). No misalignment trap.

## Timing
- Reset values:
  - pc=RESET_PC, state=S_IDLE, pend_pc=0.
  - ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_inst=NOP, ifid_opcode=7'h13.
  - ICACHE_ren=0. ICACHE_addr follows pc (RESET_PC[31:2]).
- First request: ren rises in the cycle after rst deasserts.
- Hit latency: word fetched in cycle t is in IF/ID after edge t+1. Throughput is 1 instruction/cycle.
- Redirect penalty: 1 bubble without a miss; miss remainder + 1 bubble with an outstanding miss.
- ICACHE_ren and ICACHE_addr are combinational from state and pc. The address never changes while ICACHE_stall=1.
- rst mid-miss abandons the request (the cache shares rst). The core restarts at RESET_PC.

## Structure
- Shared package rv_pkg:
  - opcode constants RTYPE/ITYPE/LOAD/SAVE/BTYPE/JTYPE/JRTYPE, shared with the decoder;
  - the NOP constant;
  - the fetch state encoding;
  - the byte-swap function.
- No sub-module. PC logic, FSM, and IF/ID register live in one block.

## Test plan
- Reset release, RESET_PC=0, cache always hits with words 0x13000000, 0x93000000: ren rises the cycle after reset; IF/ID shows pc 0 then 4, inst 0x00000013 then 0x00000093, opcode 7'h13.
- 3-cycle ICACHE_stall on pc 0x8: pc and addr held at 0x8; ifid_valid=0 for 3 cycles; then pc 0x8 enters IF/ID.
- redirect_valid with redirect_pc=0x103 while hitting at pc 0x10: next pc=0x100; one bubble (ifid_valid=0, inst=NOP); then pc 0x100 is fetched.
- Redirect to 0x40 during a 4-cycle miss at 0x20: addr stays 0x20 until stall drops; the 0x20 data is discarded; the next request is 0x40; no valid IF/ID for pc 0x20.
- stall_id high 2 cycles concurrent with redirect on the 2nd cycle: IF/ID frozen in cycle 1; the redirect wins in cycle 2 (bubble, pc=target).
- pc=0xFFFFFFFC hit: next pc=0; ifid_pc4=0. rst asserted mid-miss: all outputs return to reset values next edge.
